// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci LFSR with wrap detection, period measurement and lockup flag (optional LFSR_LOCKUP_RECOVER_EN)
module lfsr_gen #(
    parameter int unsigned          WIDTH = 4,
    parameter logic [WIDTH-1:0]     TAPS  = 4'b0011,
    parameter logic [WIDTH-1:0]     SEED  = 4'b1000
) (
    input  logic                    clk,
    input  logic                    aset,
    input  logic                    ena,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    output logic [WIDTH-1:0]        cnt_qout,
    output logic                    bit_out,
    output logic                    wrap,
    output logic [WIDTH-1:0]        period,
    output logic                    lockup
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] next_q;
    logic             recover;

    // Right shift with the XOR of the tapped bits entering at the MSB
    always_comb begin
        next_q = {^(cnt_qout & TAPS), cnt_qout[WIDTH-1:1]};
    end

    assign bit_out = cnt_qout[0];
    assign lockup  = (cnt_qout == ZERO);

`ifdef LFSR_LOCKUP_RECOVER_EN
    // A step out of the all-zero state restarts the sequence from SEED
    assign recover = lockup;
`else
    // All-zero state is sticky; only load or aset leave it
    assign recover = 1'b0;
`endif

    // State, step counter, period latch and wrap pulse; load beats ena, aset beats everything
    always_ff @(posedge clk or posedge aset) begin
        if (aset) begin
            cnt_qout <= SEED;
            step_cnt <= ZERO;
            period   <= ZERO;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                cnt_qout <= load_val;
                step_cnt <= ZERO;
            end else if (ena) begin
                if (recover) begin
                    cnt_qout <= SEED;
                    step_cnt <= ZERO;
                end else begin
                    cnt_qout <= next_q;
                    if (next_q == SEED) begin
                        wrap     <= 1'b1;
                        period   <= step_cnt + ONE;
                        step_cnt <= ZERO;
                    end else begin
                        step_cnt <= step_cnt + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen (default parameters)
module tb_lfsr_gen;

    logic       clk;
    logic       aset;
    logic       ena;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cnt_qout;
    logic       bit_out;
    logic       wrap;
    logic [3:0] period;
    logic       lockup;

    int total;
    int bad;

    logic [3:0] seq [0:15];

    lfsr_gen dut (
        .clk      (clk),
        .aset     (aset),
        .ena      (ena),
        .load     (load),
        .load_val (load_val),
        .cnt_qout (cnt_qout),
        .bit_out  (bit_out),
        .wrap     (wrap),
        .period   (period),
        .lockup   (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        seq[0]  = 4'b1000; seq[1]  = 4'b0100; seq[2]  = 4'b0010; seq[3]  = 4'b1001;
        seq[4]  = 4'b1100; seq[5]  = 4'b0110; seq[6]  = 4'b1011; seq[7]  = 4'b0101;
        seq[8]  = 4'b1010; seq[9]  = 4'b1101; seq[10] = 4'b1110; seq[11] = 4'b1111;
        seq[12] = 4'b0111; seq[13] = 4'b0011; seq[14] = 4'b0001; seq[15] = 4'b1000;

        aset = 1'b1; ena = 1'b0; load = 1'b0; load_val = 4'b0000;
        #12;
        aset = 1'b0;
        #1;
        chk("rst_q",      cnt_qout, 4'b1000);
        chk("rst_period", period,   4'd0);
        chk("rst_wrap",   wrap,     1'b0);
        chk("rst_lockup", lockup,   1'b0);
        chk("rst_bit",    bit_out,  1'b0);

        // full cycle from SEED
        ena = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("seq_q",    cnt_qout, seq[i+1]);
            chk("seq_wrap", wrap,     (i == 14));
            chk("seq_bit",  bit_out,  seq[i+1][0]);
        end
        chk("seq_period", period, 4'd15);

        // advance to 0110, then hold with ena low
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("adv_q", cnt_qout, seq[i]);
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q",    cnt_qout, 4'b0110);
            chk("hold_wrap", wrap,     1'b0);
        end
        ena = 1'b1;
        for (int i = 6; i <= 15; i++) begin
            tick();
            chk("resume_q",    cnt_qout, seq[i]);
            chk("resume_wrap", wrap,     (i == 15));
        end
        chk("resume_period", period, 4'd15);

        // load with ena high: load wins, no wrap
        load = 1'b1; load_val = 4'b0101;
        tick();
        load = 1'b0;
        chk("load_q",    cnt_qout, 4'b0101);
        chk("load_wrap", wrap,     1'b0);
        for (int i = 8; i <= 15; i++) begin
            tick();
            chk("load_seq_q",    cnt_qout, seq[i]);
            chk("load_seq_wrap", wrap,     (i == 15));
        end
        chk("load_period", period, 4'd8);

        // loading SEED does not pulse wrap
        load = 1'b1; load_val = 4'b1000;
        tick();
        load = 1'b0;
        chk("ldseed_q",    cnt_qout, 4'b1000);
        chk("ldseed_wrap", wrap,     1'b0);

        // all-zero lockup
        load = 1'b1; load_val = 4'b0000;
        tick();
        load = 1'b0;
        chk("lock_q",      cnt_qout, 4'b0000);
        chk("lock_flag",   lockup,   1'b1);
`ifdef LFSR_LOCKUP_RECOVER_EN
        tick();
        chk("recover_q",    cnt_qout, 4'b1000);
        chk("recover_lock", lockup,   1'b0);
        chk("recover_wrap", wrap,     1'b0);
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stuck_q",    cnt_qout, 4'b0000);
            chk("stuck_lock", lockup,   1'b1);
            chk("stuck_wrap", wrap,     1'b0);
        end
`endif

        // asynchronous reset between edges at state 1101
        ena = 1'b0;
        load = 1'b1; load_val = 4'b1101;
        tick();
        load = 1'b0;
        chk("pre_aset_q", cnt_qout, 4'b1101);
        #2;
        aset = 1'b1;
        #1;
        chk("aset_q",      cnt_qout, 4'b1000);
        chk("aset_period", period,   4'd0);
        chk("aset_wrap",   wrap,     1'b0);

        // load and ena ignored while aset high
        load = 1'b1; load_val = 4'b0101; ena = 1'b1;
        tick();
        chk("aset_hold_q", cnt_qout, 4'b1000);
        load = 1'b0;
        #2;
        aset = 1'b0;
        tick();
        chk("post_aset_q", cnt_qout, 4'b0100);
        ena = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
